// File: rtl/interconnect_pipe.sv
// interconnect_pipe
//   Registered 1-to-N memory-mapped bus decoder between one control-bus
//   master and NUM_PORTS peripheral register blocks. A request is sampled
//   in IDLE. Its address is decoded against the BASE/MASK map, with the
//   lowest index winning on overlap. The access is then replayed
//   downstream from registers, so no combinational path crosses the block.
//   Unmapped or read+write requests complete with DECODEERROR and never
//   touch a port. A hung peripheral is cut off after TIMEOUT_CYCLES strobe
//   cycles with SLVERR.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   s0_bus_*            upstream master: addr/read/write/writedata/byteenable
//                       in; readdata/response/waitrequest out
//   m_bus_addr          shared latched address, low SLV_ADDR_W bits
//   m_bus_writedata     shared latched write data
//   m_bus_byteenable    shared latched byte enables
//   m_bus_read/write    one-hot per-port strobes (registered)
//   m_bus_readdata      per-port read data, port i at [32i+31:32i]
//   m_bus_response      per-port response, port i at [2i+1:2i]
//   m_bus_waitrequest   per-port waitrequest
//   err_count           saturating count of non-OKAY completions
module interconnect_pipe #(
    parameter int                      NUM_PORTS      = 10,
    parameter int                      SLV_ADDR_W     = 8,
    parameter logic [NUM_PORTS*32-1:0] BASE_LIST      = (NUM_PORTS*32)'({
        32'h0000_0F00, 32'h0000_0E00, 32'h0000_0D00, 32'h0000_0C00,
        32'h0000_0B00, 32'h0000_0A00, 32'h0000_0900, 32'h0000_0800,
        32'h0000_0700, 32'h0000_0600, 32'h0000_0500, 32'h0000_0400,
        32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000}),
    parameter logic [NUM_PORTS*32-1:0] MASK_LIST      = {NUM_PORTS{32'hFFFF_FF00}},
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               s0_bus_addr,
    input  logic                      s0_bus_read,
    input  logic                      s0_bus_write,
    input  logic [31:0]               s0_bus_writedata,
    input  logic [3:0]                s0_bus_byteenable,
    output logic [31:0]               s0_bus_readdata,
    output logic [1:0]                s0_bus_response,
    output logic                      s0_bus_waitrequest,
    output logic [SLV_ADDR_W-1:0]     m_bus_addr,
    output logic [31:0]               m_bus_writedata,
    output logic [3:0]                m_bus_byteenable,
    output logic [NUM_PORTS-1:0]      m_bus_read,
    output logic [NUM_PORTS-1:0]      m_bus_write,
    input  logic [NUM_PORTS*32-1:0]   m_bus_readdata,
    input  logic [NUM_PORTS*2-1:0]    m_bus_response,
    input  logic [NUM_PORTS-1:0]      m_bus_waitrequest,
    output logic [7:0]                err_count
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state, state_next;
    logic [SLV_ADDR_W-1:0]  addr_reg, addr_next;
    logic [31:0]            wdata_reg, wdata_next;
    logic [3:0]             be_reg, be_next;
    logic                   write_reg, write_next;
    logic [PORT_W-1:0]      port_reg, port_next;
    logic [NUM_PORTS-1:0]   rd_strobe, rd_strobe_next;
    logic [NUM_PORTS-1:0]   wr_strobe, wr_strobe_next;
    logic [31:0]            rdata_reg, rdata_next;
    logic [1:0]             resp_reg, resp_next;
    logic [TMO_W-1:0]       tmo_reg, tmo_next;
    logic [7:0]             err_reg, err_next;

    logic                   hit;
    logic [PORT_W-1:0]      hit_idx;
    logic                   sel_wait;
    logic [31:0]            sel_rdata;
    logic [1:0]             sel_resp;
    logic [31:0]            tmo_plus;

    function automatic logic [7:0] err_bump(input logic [7:0] cnt, input logic [1:0] resp);
        if (resp != RESP_OKAY && cnt != 8'hFF) begin
            return cnt + 8'd1;
        end
        return cnt;
    endfunction

    // Address decode: scan downward so the lowest matching index is the last
    // one assigned and therefore wins on overlapping windows.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if ((s0_bus_addr & MASK_LIST[32*i +: 32]) == BASE_LIST[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = PORT_W'(i);
            end
        end
    end

    // Mux the latched port's response signals.
    always_comb begin
        sel_wait  = 1'b1;
        sel_rdata = '0;
        sel_resp  = RESP_OKAY;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_reg == PORT_W'(i)) begin
                sel_wait  = m_bus_waitrequest[i];
                sel_rdata = m_bus_readdata[32*i +: 32];
                sel_resp  = m_bus_response[2*i +: 2];
            end
        end
    end

    assign tmo_plus = 32'(tmo_reg) + 32'd1;

    always_comb begin
        state_next     = state;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        be_next        = be_reg;
        write_next     = write_reg;
        port_next      = port_reg;
        rd_strobe_next = rd_strobe;
        wr_strobe_next = wr_strobe;
        rdata_next     = rdata_reg;
        resp_next      = resp_reg;
        tmo_next       = tmo_reg;
        err_next       = err_reg;

        case (state)
            IDLE: begin
                if (s0_bus_read || s0_bus_write) begin
                    addr_next  = s0_bus_addr[SLV_ADDR_W-1:0];
                    wdata_next = s0_bus_writedata;
                    be_next    = s0_bus_byteenable;
                    write_next = s0_bus_write;
                    port_next  = hit_idx;
                    tmo_next   = '0;
                    if ((s0_bus_read && s0_bus_write) || !hit) begin
                        // Decode error: answer locally, no downstream strobe.
                        rdata_next = '0;
                        resp_next  = RESP_DECERR;
                        err_next   = err_bump(err_reg, RESP_DECERR);
                        state_next = DONE;
                    end else begin
                        rd_strobe_next = '0;
                        wr_strobe_next = '0;
                        if (s0_bus_write) begin
                            wr_strobe_next[hit_idx] = 1'b1;
                        end else begin
                            rd_strobe_next[hit_idx] = 1'b1;
                        end
                        state_next = ACCESS;
                    end
                end
            end

            ACCESS: begin
                if (!sel_wait) begin
                    rdata_next     = write_reg ? 32'd0 : sel_rdata;
                    resp_next      = sel_resp;
                    err_next       = err_bump(err_reg, sel_resp);
                    rd_strobe_next = '0;
                    wr_strobe_next = '0;
                    state_next     = DONE;
                end else if (TIMEOUT_CYCLES != 0 && tmo_plus == 32'(TIMEOUT_CYCLES)) begin
                    // This strobe cycle was the last one allowed.
                    rdata_next     = '0;
                    resp_next      = RESP_SLVERR;
                    err_next       = err_bump(err_reg, RESP_SLVERR);
                    rd_strobe_next = '0;
                    wr_strobe_next = '0;
                    state_next     = DONE;
                end else begin
                    tmo_next = TMO_W'(tmo_plus);
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
            port_reg  <= '0;
            rd_strobe <= '0;
            wr_strobe <= '0;
            rdata_reg <= '0;
            resp_reg  <= RESP_OKAY;
            tmo_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state     <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            write_reg <= write_next;
            port_reg  <= port_next;
            rd_strobe <= rd_strobe_next;
            wr_strobe <= wr_strobe_next;
            rdata_reg <= rdata_next;
            resp_reg  <= resp_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    assign s0_bus_waitrequest = (state != DONE);
    assign s0_bus_readdata    = rdata_reg;
    assign s0_bus_response    = resp_reg;
    assign m_bus_addr         = addr_reg;
    assign m_bus_writedata    = wdata_reg;
    assign m_bus_byteenable   = be_reg;
    assign m_bus_read         = rd_strobe;
    assign m_bus_write        = wr_strobe;
    assign err_count          = err_reg;

endmodule

// File: tb/tb_interconnect_pipe.sv
// tb_interconnect_pipe
//   Scoreboard bench for interconnect_pipe. The stimulus pushes expected
//   completions into a queue. A negedge monitor pops and compares them, and
//   also checks every downstream strobe cycle. Peripherals are modelled
//   with per-port wait counts, read data and responses.
module tb_interconnect_pipe;
    localparam int NP  = 10;
    localparam int TMO = 255;

    // Port 2 uses a widened mask so that it also claims 0x4xx (overlap with port 4).
    localparam logic [NP*32-1:0] BASES = {32'h0000_0900, 32'h0000_0800, 32'h0000_0700,
        32'h0000_0600, 32'h0000_0500, 32'h0000_0400, 32'h0000_0300, 32'h0000_0000,
        32'h0000_0100, 32'h0000_0000};
    localparam logic [NP*32-1:0] MASKS = {{7{32'hFFFF_FF00}}, 32'hFFFF_F900, {2{32'hFFFF_FF00}}};

    localparam logic [31:0] BASE_M [NP] = '{32'h000, 32'h100, 32'h000, 32'h300, 32'h400,
        32'h500, 32'h600, 32'h700, 32'h800, 32'h900};
    localparam logic [31:0] MASK_M [NP] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F900,
        32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00,
        32'hFFFF_FF00, 32'hFFFF_FF00};

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          strobes;
        int          done_cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [31:0]       s_addr;
    logic              s_read;
    logic              s_write;
    logic [31:0]       s_wdata;
    logic [3:0]        s_be;
    logic [31:0]       s0_bus_readdata;
    logic [1:0]        s0_bus_response;
    logic              s0_bus_waitrequest;
    logic [7:0]        m_bus_addr;
    logic [31:0]       m_bus_writedata;
    logic [3:0]        m_bus_byteenable;
    logic [NP-1:0]     m_bus_read;
    logic [NP-1:0]     m_bus_write;
    logic [NP*32-1:0]  m_rdata_vec;
    logic [NP*2-1:0]   m_resp_vec;
    logic [NP-1:0]     m_wait_vec;
    logic [7:0]        err_count;

    logic [31:0] per_rdata [NP];
    logic [1:0]  per_resp  [NP];
    logic        per_wait  [NP];
    int          wait_cfg  [NP];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    int          cur_port = -1;
    bit          cur_write = 0;
    logic [7:0]  cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_be = '0;
    int          model_err = 0;

    interconnect_pipe #(
        .NUM_PORTS      (NP),
        .SLV_ADDR_W     (8),
        .BASE_LIST      (BASES),
        .MASK_LIST      (MASKS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s0_bus_addr        (s_addr),
        .s0_bus_read        (s_read),
        .s0_bus_write       (s_write),
        .s0_bus_writedata   (s_wdata),
        .s0_bus_byteenable  (s_be),
        .s0_bus_readdata    (s0_bus_readdata),
        .s0_bus_response    (s0_bus_response),
        .s0_bus_waitrequest (s0_bus_waitrequest),
        .m_bus_addr         (m_bus_addr),
        .m_bus_writedata    (m_bus_writedata),
        .m_bus_byteenable   (m_bus_byteenable),
        .m_bus_read         (m_bus_read),
        .m_bus_write        (m_bus_write),
        .m_bus_readdata     (m_rdata_vec),
        .m_bus_response     (m_resp_vec),
        .m_bus_waitrequest  (m_wait_vec),
        .err_count          (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            m_rdata_vec[32*i +: 32] = per_rdata[i];
            m_resp_vec[2*i +: 2]    = per_resp[i];
            m_wait_vec[i]           = per_wait[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec decode rule: first (lowest) port whose masked address equals its base.
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NP; i++) begin
            if ((a & MASK_M[i]) == BASE_M[i]) return i;
        end
        return -1;
    endfunction

    // Peripheral model: the strobed port holds waitrequest for wait_cfg strobe cycles.
    int strobe_run = 0;
    always @(negedge clk) begin : periph
        int active;
        active = -1;
        for (int i = NP - 1; i >= 0; i--) begin
            if (m_bus_read[i] || m_bus_write[i]) active = i;
        end
        for (int i = 0; i < NP; i++) per_wait[i] = 1'b1;
        if (active >= 0) begin
            per_wait[active] = (strobe_run < wait_cfg[active]) ? 1'b1 : 1'b0;
            strobe_run++;
        end else begin
            strobe_run = 0;
        end
    end

    // Monitor: strobe legality every cycle, completion against the scoreboard.
    int  strobe_cnt = 0;
    bit  err_chk = 0;
    always @(negedge clk) begin : monitor
        logic [NP-1:0] exp_rd;
        logic [NP-1:0] exp_wr;
        exp_t e;
        if (!rst_n) begin
            strobe_cnt = 0;
            err_chk    = 0;
            model_err  = 0;
        end else begin
            if (err_chk) begin
                check("err_count", 32'(err_count), 32'(model_err));
                err_chk = 0;
            end
            if ((|m_bus_read) || (|m_bus_write)) begin
                strobe_cnt++;
                exp_rd = '0;
                exp_wr = '0;
                if (cur_port >= 0) begin
                    if (cur_write) exp_wr[cur_port] = 1'b1;
                    else           exp_rd[cur_port] = 1'b1;
                end
                check("strobe_read", 32'(m_bus_read), 32'(exp_rd));
                check("strobe_write", 32'(m_bus_write), 32'(exp_wr));
                check("shared_addr", 32'(m_bus_addr), 32'(cur_addr));
                check("shared_wdata_be", m_bus_writedata ^ 32'(m_bus_byteenable),
                      cur_wdata ^ 32'(cur_be));
            end
            if (!s0_bus_waitrequest) begin
                if (sbq.size() == 0) begin
                    check("spurious_completion", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("readdata", s0_bus_readdata, e.rdata);
                    check("response", 32'(s0_bus_response), 32'(e.resp));
                    check("latency", 32'(cyc), 32'(e.done_cyc));
                    check("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
                    if (e.resp != 2'b00 && model_err < 255) model_err++;
                    err_chk = 1;
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic drive_req(input logic [31:0] addr, input bit rd, input bit wr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int wt, output exp_t e);
        int p;
        int r;
        p = model_decode(addr);
        r = cyc + 1;
        if ((rd && wr) || p < 0) begin
            e.rdata = '0; e.resp = 2'b11; e.strobes = 0; e.done_cyc = r;
            cur_port = -1;
        end else begin
            wait_cfg[p] = wt;
            cur_port = p;
            if (wt >= TMO) begin
                e.rdata = '0; e.resp = 2'b10; e.strobes = TMO; e.done_cyc = r + TMO;
            end else begin
                e.rdata = wr ? 32'd0 : per_rdata[p];
                e.resp = per_resp[p];
                e.strobes = wt + 1;
                e.done_cyc = r + 1 + wt;
            end
        end
        cur_write = wr;
        cur_addr  = addr[7:0];
        cur_wdata = wdata;
        cur_be    = be;
        s_addr  = addr;
        s_wdata = wdata;
        s_be    = be;
        s_read  = rd;
        s_write = wr;
    endtask

    task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wdata, input logic [3:0] be, input int wt);
        exp_t e;
        bit   seen;
        drive_req(addr, rd, wr, wdata, be, wt, e);
        sbq.push_back(e);
        seen = 0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            if (!s0_bus_waitrequest) seen = 1;
        end
        s_read  = 1'b0;
        s_write = 1'b0;
        if (!seen) begin
            check("completion_wait", 32'd0, 32'd1);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t dummy;
        for (int i = 0; i < NP; i++) begin
            per_rdata[i] = 32'h1000_0000 + 32'(i);
            per_resp[i]  = 2'b00;
            wait_cfg[i]  = 0;
        end
        rst_n = 1'b0; s_addr = '0; s_read = 1'b0; s_write = 1'b0; s_wdata = '0; s_be = '0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 32'(s0_bus_waitrequest), 32'd1);
        check("rst_readdata", s0_bus_readdata, 32'd0);
        check("rst_response", 32'(s0_bus_response), 32'd0);
        check("rst_strobes", 32'(m_bus_read | m_bus_write), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        per_rdata[3] = 32'hA5A5_1234;
        access(32'h0000_0304, 1, 0, 32'h0, 4'h0, 0);
        access(32'h0000_0010, 0, 1, 32'hCAFE_F00D, 4'b0011, 4);
        access(32'h0001_0000, 1, 0, 32'h0, 4'h0, 0);
        access(32'h0000_0500, 1, 0, 32'h0, 4'hF, 1000);
        per_rdata[2] = 32'h2222_ABCD;
        access(32'h0000_0208, 1, 0, 32'h0, 4'hF, 1);

        // Reset while port 1 is stalled mid-access.
        drive_req(32'h0000_0100, 1, 0, 32'h0, 4'hF, 1000, dummy);
        repeat (5) @(negedge clk);
        check("stall_strobe", 32'(m_bus_read), 32'h0000_0002);
        rst_n = 1'b0;
        @(negedge clk);
        s_read = 1'b0;
        check("midrst_strobes", 32'(m_bus_read | m_bus_write), 32'd0);
        check("midrst_waitrequest", 32'(s0_bus_waitrequest), 32'd1);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_addr", 32'(m_bus_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        per_rdata[1] = 32'h0101_5A5A;
        access(32'h0000_0140, 1, 0, 32'h0, 4'hF, 2);

        per_rdata[4] = 32'h4444_4444;
        access(32'h0000_0400, 1, 0, 32'h0, 4'hF, 0);
        access(32'h0000_0300, 1, 1, 32'h1234_5678, 4'hF, 0);
        per_resp[7] = 2'b10;
        access(32'h0000_0720, 1, 0, 32'h0, 4'hF, 1);
        per_resp[7] = 2'b00;

        for (int n = 0; n < 40; n++) begin
            int          pr;
            logic [31:0] a;
            bit          rd;
            bit          wr;
            for (int i = 0; i < NP; i++) begin
                per_rdata[i] = $urandom;
                per_resp[i]  = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            end
            pr = $urandom_range(0, 10);
            a  = (pr == 10) ? (32'h0002_0000 + 32'($urandom_range(0, 255)))
                            : (32'(pr) * 32'd256 + 32'($urandom_range(0, 255)));
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd || ($urandom_range(0, 9) == 0);
            access(a, rd, wr, $urandom, 4'($urandom), $urandom_range(0, 5));
        end

        for (int n = 0; n < 260; n++) begin
            access(32'h0003_0000, 1, 0, 32'h0, 4'hF, 0);
        end
        check("err_saturated", 32'(err_count), 32'd255);
        access(32'h0000_0900, 1, 0, 32'h0, 4'hF, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
